// File: rtl/maxplus_dot4.sv
// Streaming max-plus dot product: per beat max_i(a_i+b_i) over enabled lanes, max-accumulated until a last beat.
// Latency: accumulator updates 1 cycle after accept; result valid the cycle after the last beat is accepted.
// Backpressure: while a result is held, in_ready is 0 and input values are ignored until out_ready.
module maxplus_dot4 #(
    parameter int W  = 8,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_last,
    input  logic [4*W-1:0]  a_vec,
    input  logic [4*W-1:0]  b_vec,
    input  logic [3:0]      lane_en,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [W:0]      out_data,
    output logic            out_eps,
    output logic [1:0]      out_lane,
    output logic [CW-1:0]   out_beat,
    output logic [CW-1:0]   out_count
);

    typedef enum logic {ACC, HOLD} state_t;

    state_t          state;
    logic [W:0]      acc_val;
    logic            acc_eps;
    logic [1:0]      acc_lane;
    logic [CW-1:0]   acc_beat;
    logic [CW-1:0]   beat_cnt;

    logic [W:0]      sum [4];
    logic            bm_vld;
    logic [W:0]      bm_val;
    logic [1:0]      bm_lane;
    logic            replace;
    logic [CW-1:0]   beat_cnt_nxt;

    // Strict '>' while scanning upward keeps the lowest lane on ties.
    always_comb begin
        bm_vld  = 1'b0;
        bm_val  = '0;
        bm_lane = '0;
        for (int i = 0; i < 4; i++) begin
            sum[i] = {1'b0, a_vec[i*W +: W]} + {1'b0, b_vec[i*W +: W]};
            if (lane_en[i] && (!bm_vld || sum[i] > bm_val)) begin
                bm_vld  = 1'b1;
                bm_val  = sum[i];
                bm_lane = 2'(i);
            end
        end
    end

    assign replace      = bm_vld && (acc_eps || bm_val > acc_val);
    assign beat_cnt_nxt = (&beat_cnt) ? beat_cnt : beat_cnt + CW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ACC;
            acc_val  <= '0;
            acc_eps  <= 1'b1;
            acc_lane <= '0;
            acc_beat <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                ACC: begin
                    if (in_valid) begin
                        beat_cnt <= beat_cnt_nxt;
                        if (replace) begin
                            acc_val  <= bm_val;
                            acc_eps  <= 1'b0;
                            acc_lane <= bm_lane;
                            acc_beat <= beat_cnt;
                        end
                        if (in_last) begin
                            state <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        state    <= ACC;
                        acc_val  <= '0;
                        acc_eps  <= 1'b1;
                        acc_lane <= '0;
                        acc_beat <= '0;
                        beat_cnt <= '0;
                    end
                end
                default: state <= ACC;
            endcase
        end
    end

    // The accumulator is frozen in HOLD, so it serves directly as the registered result.
    // The epsilon accumulator always holds zeros, which yields the forced-zero outputs.
    assign in_ready  = (state == ACC);
    assign out_valid = (state == HOLD);
    assign out_data  = acc_val;
    assign out_eps   = acc_eps;
    assign out_lane  = acc_lane;
    assign out_beat  = acc_beat;
    assign out_count = beat_cnt;

endmodule

// File: doc/maxplus_dot4.md
# maxplus_dot4

Streaming max-plus dot-product engine for the max-plus datapath. Each beat presents a 4-lane operand pair (a, b) plus a 4-bit lane-enable array produced by the upstream 4-wire packer. The block reduces the beat to max_i(a_i + b_i) over enabled lanes and accumulates that maximum across beats until a `last` beat, then offers the result and its argmax on a valid/ready output port. It sits directly downstream of the packer and feeds the max-plus matrix row collector.

## Interface
- W, default 8: unsigned operand width per lane.
- CW, default 8: beat-counter width; the counter saturates at 2^CW-1.
- clk  in  1  sole clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset; release is synchronous to clk.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block accepts a beat when in_valid && in_ready.
- in_last  in  1  accepted beat closes the current reduction.
- a_vec  in  4*W  lane i = a_vec[i*W +: W].
- b_vec  in  4*W  lane i = b_vec[i*W +: W].
- lane_en  in  4  packed enable array; bit i = 0 makes lane i epsilon (-inf).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_data  out  W+1  max of a_i+b_i over all enabled lanes of all beats; 0 when out_eps.
- out_eps  out  1  1 when no lane was enabled in any beat of the reduction.
- out_lane  out  2  lane index of the winning term.
- out_beat  out  CW  beat index (0-based, saturating) of the winning term.
- out_count  out  CW  number of beats in the reduction (saturating).

## Operation
- States: ACC and HOLD. Reset goes to ACC.
- In ACC: in_ready=1 and out_valid=0.
- In HOLD: in_ready=0 and out_valid=1. All out_* are stable until the handshake.
- Per accepted beat:
  - Compute s_i = a_i + b_i in W+1 bits. No overflow is possible.
  - Beat max = largest s_i over enabled lanes. Ties go to the lowest lane index.
  - If lane_en == 0, the beat is epsilon and contributes nothing.
- Accumulator: acc_val, acc_eps, acc_lane, acc_beat, beat_cnt.
  - A non-epsilon beat replaces the accumulator if acc_eps=1 or beat max > acc_val (strict).
  - Ties keep the earlier beat.
  - On replacement, acc_eps clears and acc_beat = beat_cnt.
  - beat_cnt increments on every accepted beat and saturates at 2^CW-1.
- Accepted beat with in_last=1:
  - The accumulator update includes this beat.
  - State goes to HOLD.
  - out_count = saturating beat_cnt + 1.
- In HOLD, on out_valid && out_ready:
  - State returns to ACC.
  - Accumulator is cleared: acc_eps=1, acc_val=0, acc_lane=0, acc_beat=0, beat_cnt=0.
- out_eps=1 forces out_data=0, out_lane=0, out_beat=0.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_eps=1, out_lane=0, out_beat=0, out_count=0. Accumulator is cleared.
- Reset asserted mid-reduction or in HOLD discards all partial state immediately, without waiting for a clock edge.

## Timing
- Beat accept to accumulator update: 1 cycle, registered.
- Last beat accepted at edge N: out_valid=1 after edge N, at the earliest observed in the cycle following edge N.
- out_ready held high: HOLD lasts exactly 1 cycle, and in_ready returns 1 the cycle after the output handshake.
- Minimum per reduction: beats + 1 cycles.
- out_ready low: HOLD persists indefinitely. in_ready stays 0, and input values are ignored.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.
- in_ready depends only on state.

## Test plan
- W=8, 1 beat, last=1, a=(10,20,30,40), b=(5,5,5,5), en=4'hF -> next cycle out_valid=1, out_data=45, out_lane=3, out_beat=0, out_count=1, out_eps=0.
- 3 beats with beat maxima 100, 300, 300, last on beat 2 -> out_data=300, out_beat=1 (tie keeps earlier beat), out_count=3.
- Lane tie inside one beat: a=(255,0,255,0), b=(255,0,255,0), en=4'hF -> out_data=510, out_lane=0. Also checks the W+1 carry.
- Masking: en=4'b0100 with lane 2 sum=7 and other lanes=200 -> out_data=7, out_lane=2. A reduction with all beats en=0 -> out_eps=1, out_data=0.
- Backpressure: hold out_ready=0 for 5 cycles in HOLD with in_valid=1 toggling values -> in_ready=0 throughout and outputs stable. The handshake then returns to ACC, and the next reduction starts with beat_cnt=0.
- Reset: assert rst_n=0 asynchronously after 2 beats of a reduction, release, then send 1 beat with sum 9 -> out_data=9, out_count=1 (no residue). Also check CW=2 saturation: 6 beats -> out_count=3.
